fetch_sequencer: RTL and testbench

- Sequences the byte-addressed, combinational-read instruction memory for the single-cycle RISC-V core.
- Owns the PC and drives the memory address each cycle.
- Registers the returned word toward decode.
- Applies branch redirects and stalls, and halts cleanly on the end-of-program sentinel, a misaligned target or an out-of-range address.

---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, instruction-memory port and decode-side outputs.
// master = environment (core/memory side), slave = the sequencer.
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  err;
  logic [15:0] fetch_count;

  modport master (
    output start, stall, branch_taken, branch_target, imem_instr,
    input  imem_addr, instr_out, instr_pc, instr_valid, halted, err, fetch_count
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, imem_instr,
    output imem_addr, instr_out, instr_pc, instr_valid, halted, err, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fetch register for the single-cycle core's combinational instruction memory.
// Define FETCH_COUNT_EN to build the saturating delivered-instruction counter on fetch_count.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [31:0] SENTINEL  = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.slave   fs
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic        end_q, end_d;
  logic [1:0]  err_q, err_d;
  logic [32:0] pc_inc;
  logic [15:0] count_w;

  assign pc_inc = {1'b0, pc_q} + 33'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  // end_q marks that the last word in memory was delivered; the next
  // unstalled, unredirected cycle would fetch past the end and halts instead.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    end_d   = end_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        vld_d = 1'b0;
        if (fs.start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          err_d   = 2'd0;
          end_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!fs.stall) begin
          vld_d = 1'b0;
          if (fs.branch_taken && (fs.branch_target[1:0] != 2'b00)) begin
            state_d = S_HALT;
            err_d   = 2'd1;
          end else if (fs.branch_taken && (fs.branch_target > LAST_PC)) begin
            state_d = S_HALT;
            err_d   = 2'd2;
          end else if (fs.branch_taken) begin
            pc_d  = fs.branch_target;
            end_d = 1'b0;
          end else if (end_q) begin
            state_d = S_HALT;
            err_d   = 2'd2;
          end else if (fs.imem_instr == SENTINEL) begin
            state_d = S_HALT;
            err_d   = 2'd0;
          end else begin
            instr_d = fs.imem_instr;
            ipc_d   = pc_q;
            vld_d   = 1'b1;
            if (pc_inc > {1'b0, LAST_PC}) end_d = 1'b1;
            else                          pc_d  = pc_inc[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q;
  logic        deliver;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // vld_d rises only on a genuine delivery, so it doubles as the count enable.
  assign deliver = (state_q == S_RUN) && !fs.stall && vld_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_q <= '0;
    else if (deliver) cnt_q <= sat_inc(cnt_q);
  end

  assign count_w = cnt_q;
`else
  assign count_w = '0;
`endif

  always_comb begin
    fs.imem_addr   = pc_q;
    fs.instr_out   = instr_q;
    fs.instr_pc    = ipc_q;
    fs.instr_valid = vld_q;
    fs.halted      = (state_q == S_HALT);
    fs.err         = err_q;
    fs.fetch_count = count_w;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level fetch model predicts deliveries
// and halts; a negedge monitor pops and compares whenever an instruction is consumed or a halt appears.
module tb_fetch_sequencer;

  localparam logic [31:0] LAST = 32'h0000_007C;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
`ifdef FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .fs  (bus)
  );

  logic [31:0] mem [32];
  always_comb bus.imem_instr = mem[bus.imem_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_halt;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [1:0]  err;
    logic [31:0] addr;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_HALT} mst_e;

  exp_t        expq[$];
  mst_e        m_st;
  logic [31:0] m_pc;
  bit          m_outv;
  logic [1:0]  m_err;
  logic [15:0] m_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] shown_pc();
    return (m_pc > LAST) ? LAST : m_pc;
  endfunction

  task automatic model_reset();
    m_st   = M_IDLE;
    m_pc   = 32'h0;
    m_outv = 1'b0;
    m_err  = 2'd0;
    m_cnt  = 16'h0;
    expq.delete();
  endtask

  task automatic halt_m(input logic [1:0] e);
    exp_t x;
    m_st   = M_HALT;
    m_outv = 1'b0;
    m_err  = e;
    x = '{is_halt: 1'b1, instr: 32'h0, pc: 32'h0, cnt: m_cnt, err: e, addr: shown_pc()};
    expq.push_back(x);
  endtask

  // Fetch rules: redirects outrank everything; an out-of-range fetch address or the
  // sentinel word halts; anything else is delivered and the PC steps by one word.
  task automatic model(input bit st, input bit sl, input bit br, input logic [31:0] tgt);
    exp_t x;
    if (m_st != M_RUN) begin
      if (st) begin
        m_st = M_RUN; m_pc = 32'h0; m_err = 2'd0; m_outv = 1'b0;
      end
    end else if (!sl) begin
      if (br) begin
        if (tgt % 4 != 0)   halt_m(2'd1);
        else if (tgt > LAST) halt_m(2'd2);
        else begin m_pc = tgt; m_outv = 1'b0; end
      end else if (m_pc > LAST) begin
        halt_m(2'd2);
      end else if (mem[m_pc >> 2] == SENT) begin
        halt_m(2'd0);
      end else begin
        if (CNT_EN && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        x = '{is_halt: 1'b0, instr: mem[m_pc >> 2], pc: m_pc, cnt: m_cnt, err: 2'd0, addr: 32'h0};
        expq.push_back(x);
        m_outv = 1'b1;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit st, input bit sl, input bit br, input logic [31:0] tgt);
    bus.start = st; bus.stall = sl; bus.branch_taken = br; bus.branch_target = tgt;
    model(st, sl, br, tgt);
    @(posedge clk); #1;
    chk("halted", 32'(bus.halted), 32'(m_st == M_HALT));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_outv));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("imem_addr", bus.imem_addr, shown_pc());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_addr"},   bus.imem_addr, 32'h0);
    chk({tag, "_instr_out"},   bus.instr_out, 32'h0);
    chk({tag, "_instr_pc"},    bus.instr_pc, 32'h0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_halted"},      32'(bus.halted), 32'h0);
    chk({tag, "_err"},         32'(bus.err), 32'h0);
    chk({tag, "_fetch_count"}, 32'(bus.fetch_count), 32'h0);
  endtask

  // Entered just after a rising edge: reset lands between edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int bound);
    for (int i = 0; i < bound && m_st != M_HALT; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("scoreboard_empty", 32'(expq.size()), 32'h0);
    expq.delete();
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    case ($urandom_range(0, 9))
      0:       t = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      1:       t = 32'h80 + (32'($urandom_range(0, 31)) << 2);
      2:       t = 32'hFFFF_FFFC;
      default: t = 32'($urandom_range(0, 31)) << 2;
    endcase
    return t;
  endfunction

  // Monitor: an instruction is consumed on an edge where it is valid and not stalled.
  initial begin : monitor
    bit   hprev;
    exp_t e;
    hprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hprev = 1'b0;
        continue;
      end
      if (bus.instr_valid && !bus.stall) begin
        if (expq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_delivery: got pc %0h want none (t=%0t)", bus.instr_pc, $time);
        end else begin
          e = expq.pop_front();
          chk("deliver_kind", 32'(e.is_halt), 32'h0);
          chk("instr_pc", bus.instr_pc, e.pc);
          chk("instr_out", bus.instr_out, e.instr);
          chk("fetch_count", 32'(bus.fetch_count), 32'(e.cnt));
        end
      end
      if (bus.halted && !hprev) begin
        if (expq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_halt: got err %0d want none (t=%0t)", bus.err, $time);
        end else begin
          e = expq.pop_front();
          chk("halt_kind", 32'(e.is_halt), 32'h1);
          chk("halt_err", 32'(bus.err), 32'(e.err));
          chk("halt_addr", bus.imem_addr, e.addr);
          chk("halt_count", 32'(bus.fetch_count), 32'(e.cnt));
        end
      end
      hprev = bus.halted;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit          sl, br, st;
    logic [31:0] tgt;
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Linear program ending on the sentinel; a few idle cycles first
    mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113; mem[2] = SENT;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until_halt(10);
    drain();

    // Stall for three cycles with instr_pc 0x04 on the output
    mem[2] = 32'h0020_0193; mem[3] = 32'h0030_0213; mem[4] = 32'h0040_0293; mem[5] = SENT;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'h8);
    run_until_halt(20);
    drain();

    // Branch to 0x10 from the instruction at 0x04
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h10);
    run_until_halt(20);
    drain();

    // Bad targets: misaligned, just past the end, wrapped
    for (int k = 0; k < 3; k++) begin
      tgt = (k == 0) ? 32'h0A : (k == 1) ? 32'h80 : 32'hFFFF_FFFC;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, tgt);
      drain();
    end

    // No sentinel anywhere: run off the end, then restart and reset mid-run
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_1000 + 32'(i);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until_halt(60);
    drain();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    async_reset();

    // Randomized programs with stalls, redirects and stray start pulses
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 32; i++)
        mem[i] = ($urandom_range(0, 23) == 0) ? SENT : ($urandom & 32'h7FFF_FFFF);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 300 && m_st == M_RUN; c++) begin
        sl  = ($urandom_range(0, 3) == 0);
        br  = m_outv && ($urandom_range(0, 5) == 0);
        st  = ($urandom_range(0, 19) == 0);
        tgt = rand_tgt();
        step(st, sl, br, tgt);
      end
      if (m_st == M_HALT) begin
        for (int c = 0; c < 3; c++) step(1'b0, bit'($urandom_range(0, 1)), 1'b1, rand_tgt());
        drain();
      end else begin
        async_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
